// File: rtl/mem_req_scheduler.sv
// Byte-serial RAM port scheduler shared by instruction fetch, load and store.
// Reads are speculative and abort on flush; stores to the IO region wait while the IO sink is full.
module mem_req_scheduler #(
  parameter int         ADR_W = 18,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             if_req,
  input  logic [ADR_W-1:0] if_adr,
  output logic             if_done,
  output logic [31:0]      if_dat,
  input  logic             ld_req,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [1:0]       ld_len,
  input  logic             ld_signed,
  output logic             ld_done,
  output logic [31:0]      ld_dat,
  input  logic             st_req,
  input  logic [ADR_W-1:0] st_adr,
  input  logic [1:0]       st_len,
  input  logic [31:0]      st_dat,
  output logic             st_done,
  input  logic             io_buffer_full,
  input  logic [7:0]       ram_dat_i,
  output logic [7:0]       ram_dat_o,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic             ram_wr_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {SRC_IF, SRC_LD, SRC_ST} src_t;

  state_t           state_q, state_d;
  src_t             src_q, src_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             fair_q, fair_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [1:0]       len_q, len_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [31:0]      rbuf_q, rbuf_d;
  logic [31:0]      if_dat_q, if_dat_d;
  logic [31:0]      ld_dat_q, ld_dat_d;

  logic [2:0] last;
  logic       io_stall;
  logic       if_ok, ld_ok;
  logic [2:0] adr_idx;

  function automatic logic [2:0] n_bytes(input logic [1:0] len);
    case (len)
      2'd0:    n_bytes = 3'd1;
      2'd1:    n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] len,
                                         input logic sgn);
    case (len)
      2'd0:    extend = {{24{sgn & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{sgn & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign last     = n_bytes(len_q);
  assign io_stall = (adr_q[ADR_W-1 -: 2] == IO_HI) && io_buffer_full;
  assign if_ok    = if_req && !flush;
  assign ld_ok    = ld_req && !flush;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    fair_d   = fair_q;
    adr_d    = adr_q;
    len_d    = len_q;
    sgn_d    = sgn_q;
    wdat_d   = wdat_q;
    rbuf_d   = rbuf_q;
    if_dat_d = if_dat_q;
    ld_dat_d = ld_dat_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          cnt_d  = 3'd0;
          rbuf_d = 32'd0;
          if (fair_q && if_ok) begin
            state_d = READ;   src_d = SRC_IF; adr_d = if_adr;
            len_d   = 2'd2;   sgn_d = 1'b0;   fair_d = 1'b0;
          end else if (st_req) begin
            state_d = WRITE;  src_d = SRC_ST; adr_d = st_adr;
            len_d   = st_len; sgn_d = 1'b0;   wdat_d = st_dat; fair_d = 1'b1;
          end else if (ld_ok) begin
            state_d = READ;   src_d = SRC_LD; adr_d = ld_adr;
            len_d   = ld_len; sgn_d = ld_signed; fair_d = 1'b1;
          end else if (if_ok) begin
            state_d = READ;   src_d = SRC_IF; adr_d = if_adr;
            len_d   = 2'd2;   sgn_d = 1'b0;   fair_d = 1'b0;
          end
        end
        READ: begin
          if (flush) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            // ram_dat_i in the cycle with counter c is byte c-1 addressed one cycle earlier
            case (cnt_q)
              3'd1:    rbuf_d[7:0]   = ram_dat_i;
              3'd2:    rbuf_d[15:8]  = ram_dat_i;
              3'd3:    rbuf_d[23:16] = ram_dat_i;
              3'd4:    rbuf_d[31:24] = ram_dat_i;
              default: ;
            endcase
            if (cnt_q == last) begin
              state_d = DONE;
              cnt_d   = 3'd0;
              if (src_q == SRC_IF) if_dat_d = rbuf_d;
              else                 ld_dat_d = extend(rbuf_d, len_q, sgn_q);
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        WRITE: begin
          if (!io_stall) begin
            if (cnt_q == last - 3'd1) begin
              state_d = DONE;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= SRC_IF;
      cnt_q    <= 3'd0;
      fair_q   <= 1'b0;
      adr_q    <= '0;
      len_q    <= 2'd0;
      sgn_q    <= 1'b0;
      wdat_q   <= 32'd0;
      rbuf_q   <= 32'd0;
      if_dat_q <= 32'd0;
      ld_dat_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
      fair_q   <= fair_d;
      adr_q    <= adr_d;
      len_q    <= len_d;
      sgn_q    <= sgn_d;
      wdat_q   <= wdat_d;
      rbuf_q   <= rbuf_d;
      if_dat_q <= if_dat_d;
      ld_dat_q <= ld_dat_d;
    end
  end

  // While frozen mid-read, re-present the previous byte's address so the pending byte is still on ram_dat_i when rdy returns
  always_comb begin
    adr_idx = cnt_q;
    if (state_q == READ && !rdy && cnt_q != 3'd0) adr_idx = cnt_q - 3'd1;
  end

  always_comb begin
    ram_adr_o = '0;
    ram_dat_o = 8'd0;
    ram_wr_o  = 1'b0;
    if (state_q == READ || state_q == WRITE) ram_adr_o = adr_q + ADR_W'(adr_idx);
    if (state_q == WRITE) begin
      case (cnt_q[1:0])
        2'd0:    ram_dat_o = wdat_q[7:0];
        2'd1:    ram_dat_o = wdat_q[15:8];
        2'd2:    ram_dat_o = wdat_q[23:16];
        default: ram_dat_o = wdat_q[31:24];
      endcase
      ram_wr_o = rdy && !io_stall;
    end
  end

  assign if_done = (state_q == DONE) && (src_q == SRC_IF) && rdy && !flush;
  assign ld_done = (state_q == DONE) && (src_q == SRC_LD) && rdy && !flush;
  assign st_done = (state_q == DONE) && (src_q == SRC_ST) && rdy;
  assign if_dat  = if_dat_q;
  assign ld_dat  = ld_dat_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: read vector table plus arbitration, IO stall, flush, rdy and reset sequences.
module tb_mem_req_scheduler;
  localparam int ADR_W = 18;

  logic             clk = 1'b0;
  logic             rst, rdy, flush;
  logic             if_req, ld_req, ld_signed, st_req, io_buffer_full;
  logic [ADR_W-1:0] if_adr, ld_adr, st_adr;
  logic [1:0]       ld_len, st_len;
  logic [31:0]      st_dat;
  logic             if_done, ld_done, st_done, ram_wr_o;
  logic [31:0]      if_dat, ld_dat;
  logic [7:0]       ram_dat_i, ram_dat_o;
  logic [ADR_W-1:0] ram_adr_o;

  logic [7:0] mem  [0:255];
  logic [7:0] wmem [0:255] = '{default: 8'd0};

  int pass_cnt = 0;
  int total    = 0;

  mem_req_scheduler #(.ADR_W(ADR_W), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_adr(if_adr), .if_done(if_done), .if_dat(if_dat),
    .ld_req(ld_req), .ld_adr(ld_adr), .ld_len(ld_len), .ld_signed(ld_signed),
    .ld_done(ld_done), .ld_dat(ld_dat),
    .st_req(st_req), .st_adr(st_adr), .st_len(st_len), .st_dat(st_dat), .st_done(st_done),
    .io_buffer_full(io_buffer_full), .ram_dat_i(ram_dat_i), .ram_dat_o(ram_dat_o),
    .ram_adr_o(ram_adr_o), .ram_wr_o(ram_wr_o)
  );

  always #5 clk = ~clk;

  // Reads come from the preloaded image; DUT writes land in a separate image
  always @(posedge clk) begin
    ram_dat_i <= mem[ram_adr_o[7:0]];
    if (ram_wr_o) wmem[ram_adr_o[7:0]] <= ram_dat_o;
  end

  typedef struct {
    string       name;
    logic        is_ld;
    logic [17:0] adr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] bytes;
    logic [31:0] exp;
    int          lat;
  } rvec_t;

  rvec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic preload(input logic [17:0] adr, input logic [31:0] b);
    for (int k = 0; k < 4; k++) begin
      logic [17:0] a;
      a = adr + 18'(k);
      mem[a[7:0]] = b[8*k +: 8];
    end
  endtask

  task automatic do_reset();
    drive();
    rst = 1'b1;
    sample();
    drive();
    sample();
    drive();
    rst = 1'b0;
    sample();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, lat, t_st, t_if, t_ld, t_done, pulses;
    logic seen;
    logic [5:0] wr_bits;
    logic [31:0] got;

    vec[0] = '{"if_word",     1'b0, 18'h00010, 2'd2, 1'b0, 32'h00000513, 32'h00000513, 5};
    vec[1] = '{"ld_byte_sx",  1'b1, 18'h00020, 2'd0, 1'b1, 32'h00000080, 32'hFFFFFF80, 2};
    vec[2] = '{"ld_byte_zx",  1'b1, 18'h00020, 2'd0, 1'b0, 32'h00000080, 32'h00000080, 2};
    vec[3] = '{"ld_half_sx",  1'b1, 18'h00040, 2'd1, 1'b1, 32'h00009234, 32'hFFFF9234, 3};
    vec[4] = '{"ld_half_zx",  1'b1, 18'h00040, 2'd1, 1'b0, 32'h00009234, 32'h00009234, 3};
    vec[5] = '{"ld_word",     1'b1, 18'h00050, 2'd2, 1'b1, 32'h12345678, 32'h12345678, 5};
    vec[6] = '{"ld_len3",     1'b1, 18'h00050, 2'd3, 1'b0, 32'h12345678, 32'h12345678, 5};
    vec[7] = '{"ld_half_wrap",1'b1, 18'h3FFFF, 2'd1, 1'b1, 32'h0000AA7F, 32'hFFFFAA7F, 3};

    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; ld_signed = 1'b0; io_buffer_full = 1'b0;
    if_adr = '0; ld_adr = '0; st_adr = '0; ld_len = 2'd0; st_len = 2'd0; st_dat = 32'd0;

    // Reset state
    sample();
    drive();
    sample();
    chk("reset_adr",   32'(ram_adr_o), 32'd0);
    chk("reset_flags", 32'({if_done, ld_done, st_done, ram_wr_o}), 32'd0);
    chk("reset_wdat",  32'(ram_dat_o), 32'd0);
    chk("reset_if_dat", if_dat, 32'd0);
    chk("reset_ld_dat", ld_dat, 32'd0);
    drive();
    rst = 1'b0;
    sample();

    // Read vector table
    for (int v = 0; v < 8; v++) begin
      logic ok;
      preload(vec[v].adr, vec[v].bytes);
      n = vec[v].is_ld ? ((vec[v].len == 2'd0) ? 1 : (vec[v].len == 2'd1) ? 2 : 4) : 4;
      drive();
      if (vec[v].is_ld) begin
        ld_req = 1'b1; ld_adr = vec[v].adr; ld_len = vec[v].len; ld_signed = vec[v].sgn;
      end else begin
        if_req = 1'b1; if_adr = vec[v].adr;
      end
      sample();
      lat = -1;
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
        logic [17:0] ea;
        drive();
        sample();
        ea = vec[v].adr + 18'(k);
        if (ram_wr_o) ok = 1'b0;
        if (k < n && ram_adr_o !== ea) ok = 1'b0;
        if (vec[v].is_ld ? ld_done : if_done) begin
          lat = k;
          break;
        end
      end
      got = vec[v].is_ld ? ld_dat : if_dat;
      chk({vec[v].name, "_addr_seq"}, 32'(ok), 32'd1);
      chk({vec[v].name, "_latency"}, 32'(lat), 32'(vec[v].lat));
      chk({vec[v].name, "_data"}, got, vec[v].exp);
      drive();
      if_req = 1'b0; ld_req = 1'b0;
      sample();
      chk({vec[v].name, "_pulse_len"}, 32'({if_done, ld_done}), 32'd0);
    end

    // Arbitration from fair = 0: ST, then IF, then LD, each separated by DONE and IDLE
    do_reset();
    preload(18'h00010, 32'h00000513);
    preload(18'h00020, 32'h00000080);
    drive();
    st_req = 1'b1; st_adr = 18'h00060; st_len = 2'd0; st_dat = 32'h000000A5;
    ld_req = 1'b1; ld_adr = 18'h00020; ld_len = 2'd0; ld_signed = 1'b0;
    if_req = 1'b1; if_adr = 18'h00010;
    sample();
    t_st = -1; t_if = -1; t_ld = -1;
    for (int c = 0; c < 40; c++) begin
      drive();
      if (t_st >= 0) st_req = 1'b0;
      if (t_if >= 0) if_req = 1'b0;
      if (t_ld >= 0) ld_req = 1'b0;
      sample();
      if (st_done && t_st < 0) t_st = c;
      if (if_done && t_if < 0) t_if = c;
      if (ld_done && t_ld < 0) t_ld = c;
    end
    chk("arb_st_done_cycle", 32'(t_st), 32'd1);
    chk("arb_if_done_cycle", 32'(t_if), 32'd8);
    chk("arb_ld_done_cycle", 32'(t_ld), 32'd12);
    chk("arb_if_dat", if_dat, 32'h00000513);
    chk("arb_ld_dat", ld_dat, 32'h00000080);
    chk("arb_st_byte", 32'(wmem[8'h60]), 32'h000000A5);

    // IO stall: buffer full for three cycles, then one byte write
    drive();
    st_req = 1'b1; st_adr = 18'h30000; st_len = 2'd0; st_dat = 32'h5A5A5AC3; io_buffer_full = 1'b1;
    sample();
    wr_bits = 6'd0; t_done = -1; got = 32'd0;
    for (int c = 0; c < 6; c++) begin
      drive();
      if (c == 3) io_buffer_full = 1'b0;
      if (t_done >= 0) st_req = 1'b0;
      sample();
      wr_bits[c] = ram_wr_o;
      if (ram_wr_o) got = {6'd0, ram_adr_o, ram_dat_o};
      if (st_done && t_done < 0) t_done = c;
    end
    chk("io_wr_pattern", 32'(wr_bits), 32'h00000008);
    chk("io_wr_adr_dat", got, {6'd0, 18'h30000, 8'hC3});
    chk("io_st_done_cycle", 32'(t_done), 32'd4);

    // Flush at G+2 of an IF word read
    preload(18'h00050, 32'h12345678);
    drive();
    if_req = 1'b1; if_adr = 18'h00050;
    sample();
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive();
      flush = (c == 2);
      if (c == 3) if_req = 1'b0;
      sample();
      if (if_done) seen = 1'b1;
      if (c == 3) chk("flush_if_idle_adr", 32'(ram_adr_o), 32'd0);
    end
    flush = 1'b0;
    chk("flush_if_no_done", 32'(seen), 32'd0);
    chk("flush_if_dat_held", if_dat, 32'h00000513);

    // Flush during a word store has no effect on it
    drive();
    st_req = 1'b1; st_adr = 18'h00070; st_len = 2'd2; st_dat = 32'hDEADBEEF;
    sample();
    t_done = -1;
    for (int c = 0; c < 8; c++) begin
      drive();
      flush = (c == 1);
      if (t_done >= 0) st_req = 1'b0;
      sample();
      if (st_done && t_done < 0) t_done = c;
    end
    flush = 1'b0;
    chk("flush_st_done_cycle", 32'(t_done), 32'd4);
    chk("flush_st_bytes", {wmem[8'h73], wmem[8'h72], wmem[8'h71], wmem[8'h70]}, 32'hDEADBEEF);

    // rdy low for two cycles in the middle of a word load
    preload(18'h00050, 32'h12345678);
    drive();
    ld_req = 1'b1; ld_adr = 18'h00050; ld_len = 2'd2; ld_signed = 1'b0;
    sample();
    t_done = -1; pulses = 0;
    for (int c = 0; c < 14; c++) begin
      drive();
      rdy = !(c == 2 || c == 3);
      if (t_done >= 0) ld_req = 1'b0;
      sample();
      if (ld_done) pulses++;
      if (ld_done && t_done < 0) t_done = c;
    end
    chk("rdy_ld_done_cycle", 32'(t_done), 32'd7);
    chk("rdy_ld_pulses", 32'(pulses), 32'd1);
    chk("rdy_ld_dat", ld_dat, 32'h12345678);

    // Reset in the middle of a word store
    drive();
    st_req = 1'b1; st_adr = 18'h00080; st_len = 2'd2; st_dat = 32'h44332211;
    sample();
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive();
      if (c == 2) begin
        rst = 1'b1;
        st_req = 1'b0;
      end
      if (c == 3) rst = 1'b0;
      sample();
      if (st_done) seen = 1'b1;
      if (c == 3) chk("rst_mid_idle", 32'({ram_adr_o, ram_wr_o}), 32'd0);
    end
    chk("rst_mid_no_done", 32'(seen), 32'd0);
    chk("rst_mid_first_byte", 32'(wmem[8'h80]), 32'h00000011);
    chk("rst_mid_last_byte", 32'(wmem[8'h83]), 32'h00000000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_req_scheduler.md
Name: mem_req_scheduler

Overview:
- Sequences the single byte-wide RAM port and shares it between three requesters: instruction fetch (IF), load (LD) and store (ST).
- Serialises multi-byte accesses and sign/zero-extends loads.
- Stalls writes to the IO region while the IO buffer is full.
- Cancels speculative reads (IF and LD) on branch flush.

Parameters:
- ADR_W, 18, RAM address width.
- IO_HI, 2'b11, value of adr[ADR_W-1:ADR_W-2] that marks the IO region.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, all state freezes
- flush  in  1  branch mispredict flush
- if_req  in  1  fetch request, held until if_done
- if_adr  in  ADR_W  fetch address
- if_done  out  1  one-cycle completion pulse
- if_dat  out  32  fetched word, little-endian
- ld_req  in  1  load request, held until ld_done
- ld_adr  in  ADR_W  load address
- ld_len  in  2  0 = byte, 1 = half, 2 = word
- ld_signed  in  1  1 = sign-extend, 0 = zero-extend
- ld_done  out  1  one-cycle completion pulse
- ld_dat  out  32  extended load result
- st_req  in  1  store request, held until st_done
- st_adr  in  ADR_W  store address
- st_len  in  2  as ld_len
- st_dat  in  32  store data; low bytes are used
- st_done  out  1  one-cycle completion pulse
- io_buffer_full  in  1  IO write sink full
- ram_dat_i  in  8  RAM read data; valid 1 cycle after its address
- ram_dat_o  out  8  RAM write data
- ram_adr_o  out  ADR_W  RAM address
- ram_wr_o  out  1  1 = write, 0 = read

Behaviour:
- Reset: state IDLE; all outputs 0; internal byte counter 0; fair bit 0.
- rdy = 0: no state, counter or output register changes; ram_wr_o forced 0.
- States: IDLE, READ, WRITE, DONE. Byte count n = 1, 2 or 4 from len (len = 3 is treated as 4).
- IDLE grant rule, evaluated at the clock edge:
  - If fair = 1 and if_req: grant IF.
  - Else priority ST > LD > IF.
  - On grant, latch address, len, signed and data.
  - Set fair = 1 when ST/LD is granted; set fair = 0 when IF is granted.
- READ, grant at cycle G:
  - Cycle G+k (k = 0..n-1): ram_adr_o = adr+k, ram_wr_o = 0.
  - Byte k is captured from ram_dat_i at cycle G+k+1.
  - After the last capture (cycle G+n), go to DONE.
  - Done pulse and data output at cycle G+n+1, so a word read completes at G+5 and a byte read at G+2.
  - ld_dat is extended per ld_signed from bit 7 (byte) or bit 15 (half).
- WRITE: cycle G+k drives ram_adr_o = adr+k, ram_dat_o = st_dat byte k, ram_wr_o = 1; st_done at G+n.
- IO stall: if the latched address is in the IO region and io_buffer_full = 1, the current byte holds with ram_wr_o = 0; the counter does not advance. The write resumes on the first cycle io_buffer_full = 0.
- DONE:
  - The done pulse lasts exactly one cycle; if_dat and ld_dat hold their value until the next completion of that port.
  - All requests are ignored in the DONE cycle; the next grant is at DONE+1 at the earliest. A requester must drop its req by DONE+1 unless it is issuing a new request.
- Address arithmetic wraps modulo 2^ADR_W.
- flush, in any state:
  - An in-flight IF or LD aborts: next state IDLE, no done pulse, no data update.
  - An IF/LD in DONE has its pulse suppressed.
  - if_req/ld_req are not granted in the flush cycle.
  - An in-flight ST is unaffected and completes; an st_req present in the flush cycle may be granted.
- rst mid-operation: immediate return to reset values; a partially written word stays partially written.

Test Plan:
- Reset, then if_req with if_adr = 0x00010 and RAM bytes 13,05,00,00 -> ram_adr_o steps 0x10..0x13 with ram_wr_o = 0; if_done at G+5 with if_dat = 0x00000513.
- ld_req with ld_len = 0, ld_signed = 1 on byte 0x80 -> ld_dat = 0xFFFFFF80 at G+2. Repeat with ld_signed = 0 -> ld_dat = 0x00000080.
- st_req, ld_req and if_req asserted together with fair = 0 -> ST granted, then IF (fair = 1), then LD. Check grant order and the idle DONE cycle between each access.
- st_req to 0x30000, st_len = 0, io_buffer_full high for 3 cycles -> ram_wr_o stays 0 for 3 cycles, then one write of st_dat[7:0]; st_done on the next cycle.
- flush at G+2 of an IF word read -> no if_done and if_dat unchanged; flush during a word store -> all 4 bytes written, then st_done.
- rdy low for 2 cycles mid-read -> completion is delayed by exactly 2 cycles and data is correct.
